// File: rtl/uart_print_pkg.sv
// uart_print_pkg
// Shared definitions for the UART print transmitter: default clock and baud
// constants and the transmit FSM state encoding.
// Optional feature macro: UART_PRINT_TX_PARITY_EN adds the PARITY state.
package uart_print_pkg;

    localparam int DEFAULT_CLK_FREQ = 48000000;
    localparam int DEFAULT_BAUD     = 115200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_PRINT_TX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } tx_state_e;

endpackage

// File: rtl/print_fifo.sv
// print_fifo
// Synchronous byte FIFO with registered full/empty flags and a
// first-word-fall-through head (head_o is valid whenever empty_o is low).
// Ports:
//   clk_i, rst_i   clock, asynchronous active-high reset
//   push_i/data_i  write strobe and data; dropped when full
//   pop_i          advance the head; ignored when empty
//   head_o         oldest stored entry
//   full_o/empty_o occupancy flags
//   overflow_o     sticky: a push was dropped, cleared only by reset
module print_fifo #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic             overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    // A push is judged against the full flag as it stood before this edge,
    // so a simultaneous pop on a full FIFO does not rescue the push.
    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    // Flags are derived from the next pointers so that, although registered,
    // they always describe the pointers they are stored alongside.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        overflow_d = overflow_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        if (push_i && full_q) begin
            overflow_d = 1'b1;
        end
        empty_d = (wr_ptr_d == rd_ptr_d);
        full_d  = (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage needs no reset: resetting the pointers discards the contents.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

    assign head_o     = mem_q[rd_ptr_q[AW-1:0]];
    assign full_o     = full_q;
    assign empty_o    = empty_q;
    assign overflow_o = overflow_q;

endmodule

// File: rtl/uart_print_tx.sv
// uart_print_tx
// Buffers bytes from a CPU print port and sends them as UART frames
// (start, 8 data bits LSB first, optional even parity, one stop bit).
// Optional feature macro: UART_PRINT_TX_PARITY_EN (8E1 instead of 8N1).
// Ports:
//   clk_i, rst_i           clock, asynchronous active-high reset
//   tf_push_i/print_data_i one-cycle byte strobe and data
//   uart_txd_o             registered serial line, idle high
//   fifo_full_o/empty_o    buffer occupancy flags
//   overflow_o             sticky dropped-byte flag
//   busy_o                 a frame is on the line
module uart_print_tx
    import uart_print_pkg::*;
#(
    parameter int CLK_FREQ   = DEFAULT_CLK_FREQ,
    parameter int BAUD       = DEFAULT_BAUD,
    parameter int FIFO_DEPTH = 16
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       tf_push_i,
    input  logic [7:0] print_data_i,
    output logic       uart_txd_o,
    output logic       fifo_full_o,
    output logic       fifo_empty_o,
    output logic       overflow_o,
    output logic       busy_o
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             txd_q, txd_d;
`ifdef UART_PRINT_TX_PARITY_EN
    logic             parity_q, parity_d;
`endif
    logic             fifo_pop;
    logic [7:0]       fifo_head;
    logic             fifo_empty;
    logic             bit_done;

    print_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .push_i     (tf_push_i),
        .data_i     (print_data_i),
        .pop_i      (fifo_pop),
        .head_o     (fifo_head),
        .full_o     (fifo_full_o),
        .empty_o    (fifo_empty),
        .overflow_o (overflow_o)
    );

    assign bit_done = (baud_cnt_q == CNT_LAST);

    // The line level is a function of the current state and is registered,
    // so the line trails the state register by one cycle. Leaving STOP with
    // data waiting reloads and goes straight to START, giving no idle gap.
    always_comb begin
        state_d    = state_q;
        baud_cnt_d = baud_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        txd_d      = 1'b1;
        fifo_pop   = 1'b0;
`ifdef UART_PRINT_TX_PARITY_EN
        parity_d   = parity_q;
`endif
        if (state_q != ST_IDLE) begin
            baud_cnt_d = bit_done ? '0 : baud_cnt_q + CNT_ONE;
        end
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop   = 1'b1;
                    shift_d    = fifo_head;
`ifdef UART_PRINT_TX_PARITY_EN
                    parity_d   = ^fifo_head;
`endif
                    baud_cnt_d = '0;
                    bit_idx_d  = '0;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                txd_d = 1'b0;
                if (bit_done) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                txd_d = shift_q[0];
                if (bit_done) begin
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
`ifdef UART_PRINT_TX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
`ifdef UART_PRINT_TX_PARITY_EN
            ST_PARITY: begin
                txd_d = parity_q;
                if (bit_done) begin
                    state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                txd_d = 1'b1;
                if (bit_done) begin
                    if (!fifo_empty) begin
                        fifo_pop  = 1'b1;
                        shift_d   = fifo_head;
`ifdef UART_PRINT_TX_PARITY_EN
                        parity_d  = ^fifo_head;
`endif
                        bit_idx_d = '0;
                        state_d   = ST_START;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            baud_cnt_q <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            txd_q      <= 1'b1;
`ifdef UART_PRINT_TX_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            txd_q      <= txd_d;
`ifdef UART_PRINT_TX_PARITY_EN
            parity_q   <= parity_d;
`endif
        end
    end

    assign uart_txd_o   = txd_q;
    assign fifo_empty_o = fifo_empty;
    assign busy_o       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_print_tx.sv
// tb_uart_print_tx
// Directed bench for uart_print_tx. The DUT runs at 4.8 MHz / 115200 baud,
// which truncates to 41 clocks per bit, to keep long FIFO sequences short.
// Follows UART_PRINT_TX_PARITY_EN for frame length and the parity bit.
module tb_uart_print_tx;

    localparam int TB_CLK_FREQ = 4_800_000;
    localparam int TB_BAUD     = 115_200;
    localparam int DIV         = 41;
    localparam int HALF        = 20;
`ifdef UART_PRINT_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FRAME = NB * DIV;

    typedef struct {
        int   cyc;
        logic txd;
        logic busy;
        logic empty;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tf_push = 1'b0;
    logic [7:0] print_data = 8'h00;
    logic       txd;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    logic       busy;

    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    vec_t vecs[$];

    uart_print_tx #(
        .CLK_FREQ   (TB_CLK_FREQ),
        .BAUD       (TB_BAUD),
        .FIFO_DEPTH (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .tf_push_i    (tf_push),
        .print_data_i (print_data),
        .uart_txd_o   (txd),
        .fifo_full_o  (fifo_full),
        .fifo_empty_o (fifo_empty),
        .overflow_o   (overflow),
        .busy_o       (busy)
    );

    // Free-running clock and an edge counter used as the time base.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Guard against a stalled run.
    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic actual, input logic expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %b expected %b", name, actual, expected);
        end
    endtask

    task automatic checkCount(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Returns on the falling edge after the given edge count, or at once
    // (just after a rising edge) if that edge has already happened.
    task automatic waitAt(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    // Expected line level for frame bit b of byte d.
    function automatic logic frameBit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (NB == 11 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic checkFrame(input logic [7:0] d, input int start, input string tag);
        for (int b = 0; b < NB; b++) begin
            waitAt(start + b * DIV + HALF);
            checkOutput($sformatf("%s bit%0d", tag, b), txd, frameBit(d, b));
        end
    endtask

    task automatic addVec(input int c, input logic t, input logic b, input logic e);
        vec_t v;
        v.cyc   = c;
        v.txd   = t;
        v.busy  = b;
        v.empty = e;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input int base);
        foreach (vecs[i]) begin
            waitAt(base + vecs[i].cyc);
            checkOutput($sformatf("vec%0d txd", i), txd, vecs[i].txd);
            checkOutput($sformatf("vec%0d busy", i), busy, vecs[i].busy);
            checkOutput($sformatf("vec%0d empty", i), fifo_empty, vecs[i].empty);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int base;
        int low_cycles;
        int busy_cycles;
        logic [7:0] b2b [3];
        b2b[0] = 8'h41;
        b2b[1] = 8'h42;
        b2b[2] = 8'h43;

        // Reset state.
        repeat (3) @(negedge clk);
        checkOutput("reset txd", txd, 1'b1);
        checkOutput("reset busy", busy, 1'b0);
        checkOutput("reset empty", fifo_empty, 1'b1);
        checkOutput("reset full", fifo_full, 1'b0);
        checkOutput("reset overflow", overflow, 1'b0);
        rst = 1'b0;
        @(negedge clk);

        // Single 0x55 frame: cycle offsets from the push edge, line level,
        // busy and empty. 0x55 goes out LSB first as 1,0,1,0,1,0,1,0.
        addVec(0, 1'b1, 1'b0, 1'b0);
        addVec(1, 1'b1, 1'b1, 1'b1);
        addVec(2, 1'b0, 1'b1, 1'b1);
        addVec(42, 1'b0, 1'b1, 1'b1);
        addVec(43, 1'b1, 1'b1, 1'b1);
        addVec(104, 1'b0, 1'b1, 1'b1);
        addVec(145, 1'b1, 1'b1, 1'b1);
        addVec(186, 1'b0, 1'b1, 1'b1);
        addVec(227, 1'b1, 1'b1, 1'b1);
        addVec(268, 1'b0, 1'b1, 1'b1);
        addVec(309, 1'b1, 1'b1, 1'b1);
        addVec(350, 1'b0, 1'b1, 1'b1);
`ifdef UART_PRINT_TX_PARITY_EN
        addVec(391, 1'b0, 1'b1, 1'b1);
`endif
        addVec(2 + (NB - 1) * DIV + HALF, 1'b1, 1'b1, 1'b1);
        addVec(FRAME, 1'b1, 1'b1, 1'b1);
        addVec(FRAME + 1, 1'b1, 1'b0, 1'b1);
        $display("[TB] single frame 0x55");
        tf_push = 1'b1;
        print_data = 8'h55;
        @(posedge clk);
        #1;
        base = cyc;
        tf_push = 1'b0;
        applyStimulus(base);

        // Three bytes pushed back to back must go out with no idle gap.
        $display("[TB] back-to-back frames");
        @(negedge clk);
        tf_push = 1'b1;
        print_data = b2b[0];
        @(posedge clk);
        #1;
        base = cyc;
        print_data = b2b[1];
        @(posedge clk);
        #1;
        print_data = b2b[2];
        @(posedge clk);
        #1;
        tf_push = 1'b0;
        checkFrame(b2b[0], base + 2, "b2b0");
        for (int k = 1; k < 3; k++) begin
            waitAt(base + 1 + k * FRAME);
            checkOutput($sformatf("b2b%0d stop before start", k), txd, 1'b1);
            checkOutput($sformatf("b2b%0d empty after pop", k), fifo_empty, (k == 2));
            waitAt(base + 2 + k * FRAME);
            checkOutput($sformatf("b2b%0d start edge", k), txd, 1'b0);
            checkFrame(b2b[k], base + 2 + k * FRAME, $sformatf("b2b%0d", k));
        end
        waitAt(base + 1 + 3 * FRAME);
        checkOutput("b2b busy end", busy, 1'b0);
        checkOutput("b2b empty end", fifo_empty, 1'b1);

        // One in flight, sixteen buffered, seventeenth dropped.
        $display("[TB] overflow sequence");
        doReset();
        tf_push = 1'b1;
        for (int i = 0; i < 18; i++) begin
            print_data = 8'(8'h10 + i);
            @(posedge clk);
            #1;
            if (i == 0) base = cyc;
            if (i == 16) begin
                checkOutput("ovf full at 16", fifo_full, 1'b1);
                checkOutput("ovf clear at 16", overflow, 1'b0);
            end
        end
        tf_push = 1'b0;
        checkOutput("ovf set", overflow, 1'b1);
        checkOutput("ovf still full", fifo_full, 1'b1);
        for (int k = 0; k < 17; k++) begin
            if (k == 1) begin
                waitAt(base + 1 + FRAME);
                checkOutput("ovf full released", fifo_full, 1'b0);
            end
            checkFrame(8'(8'h10 + k), base + 2 + k * FRAME, $sformatf("ovf%0d", k));
        end
        waitAt(base + 1 + 17 * FRAME);
        checkOutput("ovf busy end", busy, 1'b0);
        checkOutput("ovf empty end", fifo_empty, 1'b1);
        waitAt(base + 2 + 17 * FRAME + HALF);
        checkOutput("ovf dropped byte not sent", txd, 1'b1);
        checkOutput("ovf sticky", overflow, 1'b1);

        // Push into a full FIFO on the same edge as a pop.
        $display("[TB] push and pop while full");
        doReset();
        checkOutput("reset clears overflow", overflow, 1'b0);
        tf_push = 1'b1;
        for (int i = 0; i < 17; i++) begin
            print_data = 8'(8'h60 + i);
            @(posedge clk);
            #1;
            if (i == 0) base = cyc;
        end
        tf_push = 1'b0;
        checkOutput("pp full", fifo_full, 1'b1);
        checkOutput("pp overflow before", overflow, 1'b0);
        waitAt(base + FRAME);
        tf_push = 1'b1;
        print_data = 8'hEE;
        @(posedge clk);
        #1;
        tf_push = 1'b0;
        checkOutput("pp overflow after", overflow, 1'b1);
        checkOutput("pp full after", fifo_full, 1'b0);
        checkOutput("pp empty after", fifo_empty, 1'b0);
        waitAt(base + 1 + 15 * FRAME);
        checkOutput("pp one left", fifo_empty, 1'b0);
        waitAt(base + 1 + 16 * FRAME);
        checkOutput("pp drained", fifo_empty, 1'b1);
        checkFrame(8'h70, base + 2 + 16 * FRAME, "pp last");
        waitAt(base + 1 + 17 * FRAME);
        checkOutput("pp busy end", busy, 1'b0);

        // Reset in the middle of 0xA5 with three bytes queued.
        $display("[TB] reset mid frame");
        doReset();
        tf_push = 1'b1;
        print_data = 8'hA5;
        @(posedge clk);
        #1;
        base = cyc;
        for (int i = 1; i < 4; i++) begin
            print_data = 8'(i);
            @(posedge clk);
            #1;
        end
        tf_push = 1'b0;
        waitAt(base + 2 + 2 * DIV + HALF);
        checkOutput("mid A5 bit1", txd, 1'b0);
        rst = 1'b1;
        #1;
        checkOutput("mid reset txd", txd, 1'b1);
        checkOutput("mid reset busy", busy, 1'b0);
        checkOutput("mid reset empty", fifo_empty, 1'b1);
        checkOutput("mid reset full", fifo_full, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        low_cycles = 0;
        busy_cycles = 0;
        repeat (3 * FRAME) begin
            @(negedge clk);
            if (txd !== 1'b1) low_cycles++;
            if (busy !== 1'b0) busy_cycles++;
        end
        checkCount("after reset low cycles", low_cycles, 0);
        checkCount("after reset busy cycles", busy_cycles, 0);

`ifdef UART_PRINT_TX_PARITY_EN
        // 0x07 has three ones, so the even-parity bit is 1.
        $display("[TB] parity frame 0x07");
        tf_push = 1'b1;
        print_data = 8'h07;
        @(posedge clk);
        #1;
        base = cyc;
        tf_push = 1'b0;
        waitAt(base + 2 + 9 * DIV + HALF);
        checkOutput("par07 parity", txd, 1'b1);
        waitAt(base + 4576 / 416 * DIV);
        checkOutput("par07 busy last", busy, 1'b1);
        waitAt(base + 1 + 11 * DIV);
        checkOutput("par07 busy end", busy, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
